// File: rtl/perf_mon_pkg.sv
// Purpose : shared types and constants for the performance event monitor.
// Latency : n/a (declarations only).
// Backpres: n/a.
package perf_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DUMP = 2'd2,
        DONE = 2'd3
    } state_t;

    // Fixed positions of words in the snapshot stream; event k sits at IDX_EVT_BASE + k.
    localparam int IDX_CYCLE    = 0;
    localparam int IDX_PC       = 1;
    localparam int IDX_EVT_BASE = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// Purpose : W-bit up-counter that sticks at all-ones instead of wrapping.
// Latency : count visible the cycle after en_i is sampled.
// Backpres: none; clr_i has priority over en_i.
// Ports   : clk_i, rst_i (sync, active high), clr_i, en_i -> cnt_o.
module perf_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/perf_event_monitor.sv
// Purpose : counts RUN cycles and per-channel event strobes, samples the PC, then streams a snapshot.
// Latency : start_i -> running_o one cycle; dump trigger -> trace_valid_o one cycle.
// Backpres: trace_idx_o/trace_data_o hold while valid && !ready; one word per cycle when ready stays high.
// Ports   : clk_i, rst_i (sync, active high); start_i, dump_req_i, cycle_limit_i control the run;
//           event_i, pc_i are the observed core signals; trace_valid_o/trace_ready_i/trace_idx_o/
//           trace_data_o form the snapshot stream; running_o/done_o report the state.
module perf_event_monitor
    import perf_mon_pkg::*;
#(
    parameter int NUM_EVENTS = 4,
    parameter int CNT_W      = 32,
    parameter int LIMIT_W    = 16,
    parameter int PC_W       = 32
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    input  logic                                dump_req_i,
    input  logic [LIMIT_W-1:0]                  cycle_limit_i,
    input  logic [NUM_EVENTS-1:0]               event_i,
    input  logic [PC_W-1:0]                     pc_i,
    output logic                                trace_valid_o,
    input  logic                                trace_ready_i,
    output logic [$clog2(NUM_EVENTS+2)-1:0]     trace_idx_o,
    output logic [max_int(CNT_W, PC_W)-1:0]     trace_data_o,
    output logic                                running_o,
    output logic                                done_o
);

    localparam int IDX_W  = $clog2(NUM_EVENTS + 2);
    localparam int DATA_W = max_int(CNT_W, PC_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EVENTS + 1);

    state_t               r_state;
    logic [LIMIT_W-1:0]   r_limit;
    // Run length tracked at limit width so the auto-dump fires on time even when
    // the cycle counter is narrower than the limit and has already saturated.
    logic [LIMIT_W-1:0]   r_run_cnt;
    logic [PC_W-1:0]      r_last_pc;
    logic                 r_valid;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_running;
    logic                 r_done;

    logic                 w_start;
    logic                 w_count;
    logic                 w_trigger;
    logic                 w_accept;
    logic [CNT_W-1:0]     w_cycle_cnt;
    logic [CNT_W-1:0]     w_evt_cnt [NUM_EVENTS];
    logic [DATA_W-1:0]    w_data;

    assign w_start   = ((r_state == IDLE) || (r_state == DONE)) && start_i;
    assign w_count   = (r_state == RUN);
    assign w_trigger = (r_state == RUN) &&
                       (((r_limit != '0) && ((r_run_cnt + LIMIT_W'(1)) == r_limit)) || dump_req_i);
    assign w_accept  = r_valid && trace_ready_i;

    perf_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (w_start),
        .en_i  (w_count),
        .cnt_o (w_cycle_cnt)
    );

    for (genvar k = 0; k < NUM_EVENTS; k++) begin : g_evt
        perf_sat_counter #(.W(CNT_W)) u_evt_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (w_start),
            .en_i  (w_count && event_i[k]),
            .cnt_o (w_evt_cnt[k])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_limit   <= '0;
            r_run_cnt <= '0;
            r_last_pc <= '0;
            r_valid   <= 1'b0;
            r_idx     <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start_i) begin
                        r_state   <= RUN;
                        r_limit   <= cycle_limit_i;
                        r_run_cnt <= '0;
                        r_last_pc <= '0;
                        r_running <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                RUN: begin
                    r_run_cnt <= r_run_cnt + LIMIT_W'(1);
                    r_last_pc <= pc_i;
                    if (w_trigger) begin
                        r_state   <= DUMP;
                        r_running <= 1'b0;
                        r_valid   <= 1'b1;
                        r_idx     <= '0;
                    end
                end
                DUMP: begin
                    if (w_accept) begin
                        if (r_idx == LAST_IDX) begin
                            r_state <= DONE;
                            r_valid <= 1'b0;
                            r_idx   <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Counters are frozen while dumping, so a mux on the registered index gives a stable word.
    always_comb begin
        w_data = '0;
        if (r_valid) begin
            if (r_idx == IDX_W'(IDX_CYCLE)) begin
                w_data = DATA_W'(w_cycle_cnt);
            end else if (r_idx == IDX_W'(IDX_PC)) begin
                w_data = DATA_W'(r_last_pc);
            end else begin
                for (int k = 0; k < NUM_EVENTS; k++) begin
                    if (r_idx == IDX_W'(IDX_EVT_BASE + k)) begin
                        w_data = DATA_W'(w_evt_cnt[k]);
                    end
                end
            end
        end
    end

    assign trace_valid_o = r_valid;
    assign trace_idx_o   = r_idx;
    assign trace_data_o  = w_data;
    assign running_o     = r_running;
    assign done_o        = r_done;

endmodule

// File: tb/tb_perf_event_monitor.sv
// Purpose : directed self-checking bench for perf_event_monitor (default and 4-bit counter builds).
// Latency : inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpres: exercises stalled, toggling and always-ready consumers.
module tb_perf_event_monitor;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default build
    logic        rst, start, dump_req, ready;
    logic [15:0] limit;
    logic [3:0]  evt;
    logic [31:0] pc;
    logic        valid, running, done;
    logic [2:0]  idx;
    logic [31:0] data;

    // 4-bit counter build
    logic        s_rst, s_start, s_dump_req, s_ready;
    logic [15:0] s_limit;
    logic [3:0]  s_evt;
    logic [31:0] s_pc;
    logic        s_valid, s_running, s_done;
    logic [2:0]  s_idx;
    logic [31:0] s_data;

    int checks = 0;
    int errors = 0;

    perf_event_monitor u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .dump_req_i(dump_req),
        .cycle_limit_i(limit), .event_i(evt), .pc_i(pc),
        .trace_valid_o(valid), .trace_ready_i(ready), .trace_idx_o(idx),
        .trace_data_o(data), .running_o(running), .done_o(done)
    );

    perf_event_monitor #(.CNT_W(4)) u_dut_sat (
        .clk_i(clk), .rst_i(s_rst), .start_i(s_start), .dump_req_i(s_dump_req),
        .cycle_limit_i(s_limit), .event_i(s_evt), .pc_i(s_pc),
        .trace_valid_o(s_valid), .trace_ready_i(s_ready), .trace_idx_o(s_idx),
        .trace_data_o(s_data), .running_o(s_running), .done_o(s_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_rst = 1'b1;
        tick(); tick();
        rst = 1'b0; s_rst = 1'b0;
        checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %0b want 0", valid); end
        checks++; if (idx !== 3'd0)     begin errors++; $display("FAIL reset_idx: got %0d want 0", idx); end
        checks++; if (data !== 32'd0)   begin errors++; $display("FAIL reset_data: got %0h want 0", data); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %0b want 0", running); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_sat_valid: got %0b want 0", s_valid); end
    endtask

    task automatic test_auto_limit();
        logic [31:0] exp [6];
        exp = '{32'd10, 32'h1028, 32'd3, 32'd0, 32'd0, 32'd0};
        limit = 16'd10; start = 1'b1;
        tick();
        start = 1'b0; limit = 16'd3;  // must be ignored mid-run
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL auto_running: got %0b want 1", running); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL auto_done_low: got %0b want 0", done); end
        for (int c = 1; c <= 10; c++) begin
            evt = (c >= 2 && c <= 4) ? 4'b0001 : 4'b0000;
            pc  = 32'h1000 + 32'(c * 4);
            tick();
            if (c == 9) begin
                checks++; if (valid !== 1'b0) begin errors++; $display("FAIL auto_early_dump: got valid %0b want 0", valid); end
            end
        end
        evt = 4'hF; pc = 32'hDEAD; ready = 1'b1;  // ignored during DUMP
        for (int i = 0; i < 6; i++) begin
            checks++; if (valid !== 1'b1)    begin errors++; $display("FAIL auto_valid%0d: got %0b want 1", i, valid); end
            checks++; if (idx !== i[2:0])    begin errors++; $display("FAIL auto_idx%0d: got %0d want %0d", i, idx, i); end
            checks++; if (data !== exp[i])   begin errors++; $display("FAIL auto_data%0d: got %0h want %0h", i, data, exp[i]); end
            tick();
        end
        ready = 1'b0; evt = 4'h0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL auto_valid_end: got %0b want 0", valid); end
        checks++; if (done !== 1'b1)  begin errors++; $display("FAIL auto_done: got %0b want 1", done); end
    endtask

    task automatic test_dump_req();
        logic [31:0] exp [6];
        int acc;
        exp = '{32'd7, 32'h2007, 32'd0, 32'd0, 32'd1, 32'd0};
        limit = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL req_restart_running: got %0b want 1", running); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL req_restart_done: got %0b want 0", done); end
        for (int c = 1; c <= 7; c++) begin
            evt = (c == 5) ? 4'b0100 : 4'b0000;
            pc = 32'h2000 + 32'(c);
            dump_req = (c == 7);
            tick();
        end
        dump_req = 1'b0; evt = 4'h0; ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++; if (idx !== i[2:0] || valid !== 1'b1) begin errors++; $display("FAIL req_idx%0d: got idx %0d valid %0b want idx %0d valid 1", i, idx, valid, i); end
            checks++; if (data !== exp[i]) begin errors++; $display("FAIL req_data%0d: got %0h want %0h", i, data, exp[i]); end
            tick();
        end
        ready = 1'b0;
        // limit and dump_req coincide on cycle 7: exactly one snapshot
        limit = 16'd7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            dump_req = (c == 7);
            tick();
        end
        dump_req = 1'b0;
        checks++; if (data !== 32'd7) begin errors++; $display("FAIL both_cycle_word: got %0d want 7", data); end
        ready = 1'b1; acc = 0;
        for (int t = 0; t < 20; t++) begin
            if (valid && ready) acc++;
            tick();
        end
        ready = 1'b0;
        checks++; if (acc != 6)      begin errors++; $display("FAIL both_word_count: got %0d want 6", acc); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL both_done: got %0b want 1", done); end
        dump_req = 1'b1;
        tick(); tick(); tick();
        dump_req = 1'b0;
        checks++; if (valid !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL done_ignores_req: got valid %0b done %0b want 0 1", valid, done); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp [6];
        logic        rp [4];
        logic        stalled;
        logic [2:0]  hold_idx;
        logic [31:0] hold_data;
        int          acc;
        exp = '{32'd4, 32'h3004, 32'd4, 32'd3, 32'd2, 32'd1};
        rp  = '{1'b1, 1'b0, 1'b0, 1'b1};
        limit = 16'd4; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            evt = (c == 1) ? 4'hF : (c == 2) ? 4'h7 : (c == 3) ? 4'h3 : 4'h1;
            pc = 32'h3000 + 32'(c);
            tick();
        end
        evt = 4'h0;
        stalled = 1'b0; hold_idx = '0; hold_data = '0; acc = 0;
        for (int t = 0; t < 40; t++) begin
            if (stalled) begin
                checks++; if (valid !== 1'b1 || idx !== hold_idx || data !== hold_data) begin
                    errors++; $display("FAIL bp_hold t%0d: got v%0b idx %0d data %0h want v1 idx %0d data %0h", t, valid, idx, data, hold_idx, hold_data);
                end
            end
            ready = rp[t % 4];
            if (valid && ready) begin
                if (acc >= 6) begin
                    checks++; errors++; $display("FAIL bp_extra_word: got word %0d want only 6", acc);
                end else begin
                    checks++; if (idx !== acc[2:0] || data !== exp[acc]) begin
                        errors++; $display("FAIL bp_word%0d: got idx %0d data %0h want idx %0d data %0h", acc, idx, data, acc, exp[acc]);
                    end
                end
                acc++;
            end
            stalled = valid && !ready; hold_idx = idx; hold_data = data;
            tick();
        end
        ready = 1'b0;
        checks++; if (acc != 6)      begin errors++; $display("FAIL bp_word_count: got %0d want 6", acc); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %0b want 1", done); end
    endtask

    task automatic test_saturation();
        logic [31:0] exp [6];
        exp = '{32'd15, 32'h4014, 32'd0, 32'd15, 32'd0, 32'd0};
        s_limit = 16'd20; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            s_evt = 4'b0010;
            s_pc = 32'h4000 + 32'(c);
            tick();
            if (c == 19) begin
                checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL sat_early_dump: got %0b want 0", s_valid); end
            end
        end
        s_evt = 4'h0; s_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++; if (s_valid !== 1'b1 || s_idx !== i[2:0] || s_data !== exp[i]) begin
                errors++; $display("FAIL sat_word%0d: got v%0b idx %0d data %0h want v1 idx %0d data %0h", i, s_valid, s_idx, s_data, i, exp[i]);
            end
            tick();
        end
        s_ready = 1'b0;
        checks++; if (s_done !== 1'b1) begin errors++; $display("FAIL sat_done: got %0b want 1", s_done); end
    endtask

    task automatic test_reset_mid_dump();
        logic [31:0] exp [6];
        exp = '{32'd2, 32'h6002, 32'd0, 32'd0, 32'd0, 32'd1};
        limit = 16'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            evt = (c == 2) ? 4'b1000 : 4'b0000;
            pc = 32'h5000 + 32'(c);
            tick();
        end
        evt = 4'h0; ready = 1'b1;
        tick(); tick(); tick();
        ready = 1'b0;
        checks++; if (valid !== 1'b1 || idx !== 3'd3) begin errors++; $display("FAIL rst_pre_idx: got v%0b idx %0d want v1 idx 3", valid, idx); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL rst_mid_valid: got %0b want 0", valid); end
        checks++; if (idx !== 3'd0 || data !== 32'd0) begin errors++; $display("FAIL rst_mid_word: got idx %0d data %0h want 0 0", idx, data); end
        checks++; if (running !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_state: got run %0b done %0b want 0 0", running, done); end
        limit = 16'd2; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL rst_new_running: got %0b want 1", running); end
        for (int c = 1; c <= 2; c++) begin
            evt = (c == 1) ? 4'b1000 : 4'b0000;
            pc = 32'h6000 + 32'(c);
            tick();
        end
        evt = 4'h0; ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++; if (valid !== 1'b1 || idx !== i[2:0] || data !== exp[i]) begin
                errors++; $display("FAIL rst_new_word%0d: got v%0b idx %0d data %0h want v1 idx %0d data %0h", i, valid, idx, data, i, exp[i]);
            end
            tick();
        end
        ready = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rst_new_done: got %0b want 1", done); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dump_req = 1'b0; ready = 1'b0;
        limit = '0; evt = '0; pc = '0;
        s_rst = 1'b1; s_start = 1'b0; s_dump_req = 1'b0; s_ready = 1'b0;
        s_limit = '0; s_evt = '0; s_pc = '0;
        test_reset();
        test_auto_limit();
        test_dump_req();
        test_backpressure();
        test_saturation();
        test_reset_mid_dump();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
